// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - run-control FSM, hh:mm:ss elapsed counter and one-shot alarm for the timer
// The alarm (armed flag, fields, ALARM state) is built only when TIMER_CTRL_ALARM_EN is defined.

module timer_ctrl #(
  parameter int MAX_HOUR = 24
) (
  input  logic       clk_50m,
  input  logic       reset_n,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_clear,
  input  logic       one_sec_timer,
  input  logic       alarm_load,
  input  logic [5:0] alarm_sec,
  input  logic [5:0] alarm_min,
  input  logic [4:0] alarm_hour,
  input  logic       alarm_ack,
  output logic       reset_timer,
  output logic       running,
  output logic [5:0] sec_cnt,
  output logic [5:0] min_cnt,
  output logic [4:0] hour_cnt,
  output logic       alarm_irq
);

  localparam logic [4:0] HOUR_LAST = 5'(MAX_HOUR - 1);

`ifdef TIMER_CTRL_ALARM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_ALARM = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2} state_t;
`endif

  state_t     state_q, state_d;
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       reset_timer_q, reset_timer_d;
  logic       running_q, running_d;
  logic       counting, tick_ok;
  logic [5:0] sec_nxt, min_nxt;
  logic [4:0] hour_nxt;

`ifdef TIMER_CTRL_ALARM_EN
  logic       armed_q, armed_d;
  logic       alarm_irq_q, alarm_irq_d;
  logic [5:0] al_sec_q, al_sec_d, al_min_q, al_min_d;
  logic [4:0] al_hour_q, al_hour_d;
  logic       match;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_load, alarm_sec, alarm_min, alarm_hour, alarm_ack};
`endif

  // Post-increment value of the hh:mm:ss count with cascaded carries.
  always_comb begin
    sec_nxt  = sec_q + 6'd1;
    min_nxt  = min_q;
    hour_nxt = hour_q;
    if (sec_q == 6'd59) begin
      sec_nxt = 6'd0;
      min_nxt = min_q + 6'd1;
      if (min_q == 6'd59) begin
        min_nxt  = 6'd0;
        hour_nxt = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    counting = (state_q != ST_IDLE) && (state_q != ST_PAUSE);
    tick_ok  = counting && one_sec_timer && !cmd_stop && !cmd_clear;

    if (tick_ok) begin
      sec_d  = sec_nxt;
      min_d  = min_nxt;
      hour_d = hour_nxt;
    end

    if (cmd_stop && counting) begin
      state_d = ST_PAUSE;
    end else if (cmd_start && !counting) begin
      state_d = ST_RUN;
    end

`ifdef TIMER_CTRL_ALARM_EN
    armed_d     = armed_q;
    alarm_irq_d = alarm_irq_q;
    al_sec_d    = al_sec_q;
    al_min_d    = al_min_q;
    al_hour_d   = al_hour_q;
    match       = tick_ok && armed_q &&
                  ({sec_nxt, min_nxt, hour_nxt} == {al_sec_q, al_min_q, al_hour_q});

    if (alarm_ack && alarm_irq_q) alarm_irq_d = 1'b0;
    if (match) begin
      alarm_irq_d = 1'b1;
      armed_d     = 1'b0;
    end
    // A load in the match cycle re-arms with the new fields; the old ones were compared.
    if (alarm_load) begin
      al_sec_d  = alarm_sec;
      al_min_d  = alarm_min;
      al_hour_d = alarm_hour;
      armed_d   = 1'b1;
    end
    // ALARM is simply an active state with the interrupt pending.
    if (state_d == ST_RUN || state_d == ST_ALARM) begin
      state_d = alarm_irq_d ? ST_ALARM : ST_RUN;
    end
`endif

    if (cmd_clear) begin
      state_d = ST_IDLE;
      sec_d   = 6'd0;
      min_d   = 6'd0;
      hour_d  = 5'd0;
`ifdef TIMER_CTRL_ALARM_EN
      alarm_irq_d = 1'b0;
      armed_d     = 1'b0;
`endif
    end

    running_d     = (state_d != ST_IDLE) && (state_d != ST_PAUSE);
    reset_timer_d = !running_d;
  end

  always_ff @(posedge clk_50m) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sec_q         <= 6'd0;
      min_q         <= 6'd0;
      hour_q        <= 5'd0;
      reset_timer_q <= 1'b1;
      running_q     <= 1'b0;
`ifdef TIMER_CTRL_ALARM_EN
      armed_q       <= 1'b0;
      alarm_irq_q   <= 1'b0;
      al_sec_q      <= 6'd0;
      al_min_q      <= 6'd0;
      al_hour_q     <= 5'd0;
`endif
    end else begin
      state_q       <= state_d;
      sec_q         <= sec_d;
      min_q         <= min_d;
      hour_q        <= hour_d;
      reset_timer_q <= reset_timer_d;
      running_q     <= running_d;
`ifdef TIMER_CTRL_ALARM_EN
      armed_q       <= armed_d;
      alarm_irq_q   <= alarm_irq_d;
      al_sec_q      <= al_sec_d;
      al_min_q      <= al_min_d;
      al_hour_q     <= al_hour_d;
`endif
    end
  end

  assign reset_timer = reset_timer_q;
  assign running     = running_q;
  assign sec_cnt     = sec_q;
  assign min_cnt     = min_q;
  assign hour_cnt    = hour_q;
`ifdef TIMER_CTRL_ALARM_EN
  assign alarm_irq   = alarm_irq_q;
`else
  assign alarm_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - bench for timer_ctrl: vector table, directed corner sequences, random vs model
module tb_timer_ctrl;
  localparam int MAX_HOUR = 3;
  localparam int WRAP = MAX_HOUR * 3600;
`ifdef TIMER_CTRL_ALARM_EN
  localparam bit AEN = 1'b1;
`else
  localparam bit AEN = 1'b0;
`endif

  logic       clk_50m = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_start = 1'b0, cmd_stop = 1'b0, cmd_clear = 1'b0, one_sec_timer = 1'b0;
  logic       alarm_load = 1'b0, alarm_ack = 1'b0;
  logic [5:0] alarm_sec = '0, alarm_min = '0;
  logic [4:0] alarm_hour = '0;
  logic       reset_timer, running, alarm_irq;
  logic [5:0] sec_cnt, min_cnt;
  logic [4:0] hour_cnt;

  timer_ctrl #(.MAX_HOUR(MAX_HOUR)) dut (
    .clk_50m(clk_50m), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_clear(cmd_clear), .one_sec_timer(one_sec_timer), .alarm_load(alarm_load),
    .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .alarm_ack(alarm_ack), .reset_timer(reset_timer), .running(running),
    .sec_cnt(sec_cnt), .min_cnt(min_cnt), .hour_cnt(hour_cnt), .alarm_irq(alarm_irq)
  );

  always #10 clk_50m = ~clk_50m;

  int total_cnt = 0;
  int bad_cnt = 0;

  // Reference model: elapsed time as a plain number of seconds.
  int m_total = 0;
  int m_alarm = 0;
  bit m_run = 0, m_irq = 0, m_armed = 0;

  typedef struct {
    bit start, stop, clear, tick, load, ack;
    int asec;
    int e_sec, e_min;
    bit e_run, e_irq;
  } vec_t;
  vec_t tbl[12];

  function automatic int alarm_value(logic [5:0] s, logic [5:0] m, logic [4:0] h);
    if (s < 60 && m < 60 && int'(h) < MAX_HOUR) return int'(h) * 3600 + int'(m) * 60 + int'(s);
    return -1;
  endfunction

  task automatic model_step();
    bit tick, match;
    if (!reset_n) begin
      m_total = 0; m_run = 0; m_irq = 0; m_armed = 0; m_alarm = 0;
    end else begin
      tick  = m_run && one_sec_timer && !cmd_stop && !cmd_clear;
      match = 0;
      if (cmd_clear) begin
        m_run = 0; m_total = 0; m_irq = 0; m_armed = 0;
      end else begin
        if (cmd_stop && m_run) m_run = 0;
        else if (cmd_start && !m_run) m_run = 1;
        if (tick) begin
          m_total = (m_total + 1) % WRAP;
          match = m_armed && (m_total == m_alarm);
        end
        if (AEN) begin
          if (alarm_ack) m_irq = 0;
          if (match) begin m_irq = 1; m_armed = 0; end
          if (alarm_load) begin m_alarm = alarm_value(alarm_sec, alarm_min, alarm_hour); m_armed = 1; end
        end
      end
    end
  endtask

  task automatic expect_out(string name, int s, int m, int h, bit run, bit irq);
    total_cnt++;
    if (sec_cnt !== 6'(s) || min_cnt !== 6'(m) || hour_cnt !== 5'(h) ||
        running !== run || reset_timer !== !run || alarm_irq !== irq) begin
      bad_cnt++;
      $display("FAIL %s: got %0d:%0d:%0d run=%0b rt=%0b irq=%0b, want %0d:%0d:%0d run=%0b rt=%0b irq=%0b",
               name, hour_cnt, min_cnt, sec_cnt, running, reset_timer, alarm_irq,
               h, m, s, run, !run, irq);
    end
  endtask

  task automatic step(string name);
    @(posedge clk_50m);
    model_step();
    #1;
    expect_out(name, m_total % 60, (m_total / 60) % 60, m_total / 3600, m_run, m_irq);
  endtask

  task automatic clear_inputs();
    cmd_start = 0; cmd_stop = 0; cmd_clear = 0; one_sec_timer = 0;
    alarm_load = 0; alarm_ack = 0;
  endtask

  task automatic ticks(int n);
    one_sec_timer = 1;
    repeat (n) step("tick");
    one_sec_timer = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    step("reset");
    expect_out("reset_values", 0, 0, 0, 0, 0);
    reset_n = 1;
  endtask

  task automatic pulse_start();
    cmd_start = 1; step("start"); cmd_start = 0;
  endtask

  initial begin
    tbl[0]  = '{0,0,0,0,0,0, 0, 0,0, 0,0};
    tbl[1]  = '{0,0,0,0,1,0, 2, 0,0, 0,0};
    tbl[2]  = '{1,0,0,0,0,0, 0, 0,0, 1,0};
    tbl[3]  = '{0,0,0,1,0,0, 0, 1,0, 1,0};
    tbl[4]  = '{0,0,0,1,0,0, 0, 2,0, 1,AEN};
    tbl[5]  = '{0,0,0,0,0,1, 0, 2,0, 1,0};
    tbl[6]  = '{0,1,0,1,0,0, 0, 2,0, 0,0};
    tbl[7]  = '{0,0,0,1,0,0, 0, 2,0, 0,0};
    tbl[8]  = '{1,0,0,1,0,0, 0, 2,0, 1,0};
    tbl[9]  = '{0,0,0,1,0,0, 0, 3,0, 1,0};
    tbl[10] = '{1,0,1,0,0,0, 0, 0,0, 0,0};
    tbl[11] = '{0,1,0,0,0,0, 0, 0,0, 0,0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cmd_start = tbl[i].start; cmd_stop = tbl[i].stop; cmd_clear = tbl[i].clear;
      one_sec_timer = tbl[i].tick; alarm_load = tbl[i].load; alarm_ack = tbl[i].ack;
      alarm_sec = 6'(tbl[i].asec); alarm_min = 0; alarm_hour = 0;
      step($sformatf("table_%0d", i));
      expect_out($sformatf("table_exp_%0d", i), tbl[i].e_sec, tbl[i].e_min, 0, tbl[i].e_run, tbl[i].e_irq);
    end
    clear_inputs();

    // Start latency and 61 ticks.
    do_reset();
    pulse_start();
    expect_out("start_latency", 0, 0, 0, 1, 0);
    ticks(61);
    expect_out("count_61", 1, 1, 0, 1, 0);

    // Tick coincident with stop is dropped; resume continues.
    do_reset();
    pulse_start();
    ticks(5);
    cmd_stop = 1; one_sec_timer = 1; step("stop_tick"); clear_inputs();
    expect_out("stop_drops_tick", 5, 0, 0, 0, 0);
    pulse_start();
    ticks(1);
    expect_out("resume_tick", 6, 0, 0, 1, 0);

    // Alarm, ack, then full wrap with no re-fire.
    do_reset();
    alarm_load = 1; alarm_sec = 3; alarm_min = 0; alarm_hour = 0;
    step("alarm_load"); alarm_load = 0;
    pulse_start();
    ticks(3);
    expect_out("alarm_fire", 3, 0, 0, 1, AEN);
    alarm_ack = 1; step("ack"); alarm_ack = 0;
    expect_out("alarm_ack", 3, 0, 0, 1, 0);
    ticks(WRAP - 4);
    expect_out("pre_wrap", 59, 59, MAX_HOUR - 1, 1, 0);
    ticks(1);
    expect_out("wrap", 0, 0, 0, 1, 0);
    ticks(3);
    expect_out("one_shot", 3, 0, 0, 1, 0);

    // Clear beats start at 00:02:10.
    do_reset();
    pulse_start();
    ticks(130);
    expect_out("at_2_10", 10, 2, 0, 1, 0);
    cmd_clear = 1; cmd_start = 1; step("clear_start"); clear_inputs();
    expect_out("clear_wins", 0, 0, 0, 0, 0);

    // Alarm at 00:00:01, two ticks.
    do_reset();
    alarm_load = 1; alarm_sec = 1; step("load_1"); alarm_load = 0;
    pulse_start();
    ticks(2);
    expect_out("alarm_1", 2, 0, 0, 1, AEN);

    // Reset mid-run with pending commands.
    pulse_start();
    ticks(2);
    reset_n = 0; cmd_start = 1; one_sec_timer = 1; alarm_load = 1; alarm_ack = 1;
    step("reset_mid");
    expect_out("reset_mid_run", 0, 0, 0, 0, 0);
    clear_inputs();
    reset_n = 1;

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 499) != 0);
      cmd_clear     = ($urandom_range(0, 199) == 0);
      cmd_stop      = ($urandom_range(0, 39) == 0);
      cmd_start     = ($urandom_range(0, 19) == 0);
      one_sec_timer = ($urandom_range(0, 1) == 1);
      alarm_load    = ($urandom_range(0, 29) == 0);
      alarm_ack     = ($urandom_range(0, 9) == 0);
      alarm_sec     = 6'($urandom_range(0, 63));
      alarm_min     = 6'($urandom_range(0, 2));
      alarm_hour    = 5'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 31));
      step("random");
    end
    clear_inputs();
    reset_n = 1;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Run-control and alarm scheduler for the seconds/minutes/hours timer. It sequences the timer through idle, run and pause by driving its `reset_timer` input. It consumes the timer's one-second tick and keeps an hh:mm:ss elapsed count. An optional one-shot alarm raises a held interrupt when the count reaches a programmed time. It sits between the user/command logic and the timer, beside the LED controller.

## Interface
- `MAX_HOUR`, default 24: hour wrap modulus; legal range 2..32.
- `clk_50m`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_start`  in  1  single-cycle pulse: begin or resume counting.
- `cmd_stop`  in  1  single-cycle pulse: pause counting.
- `cmd_clear`  in  1  single-cycle pulse: return to idle and zero the counts.
- `one_sec_timer`  in  1  single-cycle tick from the timer.
- `alarm_load`  in  1  pulse: capture the alarm fields and arm the alarm.
- `alarm_sec`  in  6  alarm seconds.
- `alarm_min`  in  6  alarm minutes.
- `alarm_hour`  in  5  alarm hours.
- `alarm_ack`  in  1  pulse: clear `alarm_irq`.
- `reset_timer`  out  1  holds the timer's prescalers in reset.
- `running`  out  1  high in RUN and ALARM.
- `sec_cnt`  out  6  elapsed seconds, 0..59.
- `min_cnt`  out  6  elapsed minutes, 0..59.
- `hour_cnt`  out  5  elapsed hours, 0..MAX_HOUR-1.
- `alarm_irq`  out  1  alarm-reached flag; held until acknowledged.

## Operation
- States:
  - IDLE: counts are zero; `reset_timer`=1.
  - RUN: `reset_timer`=0; ticks are counted.
  - PAUSE: counts are frozen; `reset_timer`=1.
  - ALARM: same as RUN, with `alarm_irq`=1.
- Command priority: `cmd_clear` > `cmd_stop` > `cmd_start`.
- Transitions:
  - IDLE -start-> RUN.
  - RUN -stop-> PAUSE.
  - PAUSE -start-> RUN.
  - ALARM -stop-> PAUSE; `alarm_irq` stays set.
  - ALARM -ack-> RUN.
  - Any state -clear-> IDLE; counts, `alarm_irq` and armed are all cleared.
- Ignored commands, with no effect:
  - `cmd_start` in RUN or ALARM.
  - `cmd_stop` in IDLE or PAUSE.
  - `alarm_ack` while `alarm_irq`=0.
- Counting happens only in RUN or ALARM, on `one_sec_timer`=1:
  - `sec_cnt` increments.
  - 59 wraps to 0 with a carry into `min_cnt`.
  - `min_cnt` 59 wraps to 0 with a carry into `hour_cnt`.
  - `hour_cnt` MAX_HOUR-1 wraps to 0; no overflow flag.
- A tick arriving in the same cycle as `cmd_stop` or `cmd_clear` is dropped.
- The fractional second is discarded on pause, because `reset_timer` restarts the prescaler. On resume, the first tick arrives a full second after `reset_timer` deasserts.
- Alarm:
  - `alarm_load` captures all three fields and sets armed, in any state.
  - A reload while armed overwrites the fields.
  - When armed and the post-increment count equals the alarm fields: armed clears (one-shot), `alarm_irq` sets and the state goes to ALARM.
  - Out-of-range fields (for example sec > 59) never match.
  - If `alarm_ack` and a new match occur in the same cycle, the match wins and `alarm_irq` stays 1.
- `alarm_load` in the same cycle as a match: the old value is compared and the new value is armed.

## Timing
- Reset values: state=IDLE, `reset_timer`=1, `running`=0, all counts 0, `alarm_irq`=0, armed=0, alarm fields 0.
- All outputs are registered.
- Counts update 1 cycle after the tick cycle.
- `alarm_irq` asserts in the same cycle the matching count appears.
- `reset_timer` and `running` change 1 cycle after the accepted command.
- `alarm_irq` clears 1 cycle after `alarm_ack`.
- Reset mid-run: at the next clock edge with `reset_n`=0, every output returns to its reset value, regardless of pending commands or ticks.

## Configuration
- `TIMER_CTRL_ALARM_EN` defined:
  - Alarm logic, the armed flag and the ALARM state are built.
- `TIMER_CTRL_ALARM_EN` undefined:
  - `alarm_load`, `alarm_sec`, `alarm_min`, `alarm_hour` and `alarm_ack` are ignored.
  - `alarm_irq` is tied to 0.
  - The state machine has IDLE, RUN and PAUSE only; the counting behaviour is identical.

## Test plan
- Reset, `cmd_start`, then 61 ticks -> `reset_timer` 1→0 one cycle after start; final count 00:01:01; `running`=1.
- Preload the count to 23:59:59 (via ticks), then 1 tick with `MAX_HOUR`=24 -> count 00:00:00; no flag.
- RUN, 5 ticks, `cmd_stop` in the same cycle as the 6th tick -> count 00:00:05; PAUSE; `reset_timer`=1. Then `cmd_start` and 1 tick -> 00:00:06.
- `alarm_load` with 00:00:03, `cmd_start`, 3 ticks -> `alarm_irq`=1 with 00:00:03; state ALARM. `alarm_ack` -> irq 0 next cycle. Counting continues; no re-fire at the next 00:00:03 (one-shot).
- `cmd_clear` and `cmd_start` in the same cycle while in RUN at 00:02:10 -> IDLE, counts 0, `running`=0, `reset_timer`=1.
- Build without `TIMER_CTRL_ALARM_EN`, load alarm 00:00:01, run 2 ticks -> `alarm_irq` stays 0; count 00:00:02.
